// File: rtl/almost_correct_adder16.sv
// 16-bit Almost Correct Adder: each carry is speculated from a K-bit window of
// lower positions rather than the full ripple chain; the sum is registered.
module almost_correct_adder16 #(
   parameter int WIDTH = 16,
   parameter int K     = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] add1_i,
   input  logic [WIDTH-1:0] add2_i,
   output logic [WIDTH:0]   result_o
);

   logic [WIDTH-1:0] gen;
   logic [WIDTH-1:0] prop;
   logic [WIDTH:0]   carry;
   logic [WIDTH:0]   sum_next;

   assign gen  = add1_i & add2_i;
   assign prop = add1_i ^ add2_i;

   // No carry-in port, so bit 0 never receives a carry.
   assign carry[0] = 1'b0;

   // One independent short ripple chain per carry position; no chain reads
   // another chain's result, so every window settles in parallel.
   for (genvar i = 1; i <= WIDTH; i++) begin : g_window
      localparam int LO  = (i > K) ? (i - K) : 0;
      localparam int LEN = i - LO;

      logic win_carry;

      always_comb begin
         // NOTE: blocking assignments here build the chain in program order;
         // each step reads the value written by the previous iteration.
         win_carry = 1'b0;
         for (int j = 0; j < LEN; j++) begin
            win_carry = gen[LO + j] | (prop[LO + j] & win_carry);
         end
      end

      assign carry[i] = win_carry;
   end

   assign sum_next = {carry[WIDTH], prop ^ carry[WIDTH-1:0]};

   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignment for registered state avoids read/write
      // races with other clocked processes.
      if (rst_i) begin
         result_o <= '0;
      end else begin
         result_o <= sum_next;
      end
   end

endmodule

// File: tb/tb_almost_correct_adder16.sv
// Self-checking bench for almost_correct_adder16: directed corner cases plus
// random operands compared against an arithmetic window-sum reference model.
module tb_almost_correct_adder16;

   localparam int W = 16;
   localparam int K = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [W:0]    res;

   int checks = 0;
   int errors = 0;

   almost_correct_adder16 #(.WIDTH(W), .K(K)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .add1_i   (a),
      .add2_i   (b),
      .result_o (res)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W:0] observed, input logic [W:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("FAIL %s: got %05h expected %05h", tag, observed, expected);
      end
   endtask

   // Carry into bit i is the carry-out of adding the window slices [lo, i-1]
   // of both operands as plain integers.
   function automatic logic [W:0] ref_aca(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W:0] r;
      int unsigned lo, len, mask, sx, sy, c;
      r = '0;
      for (int i = 0; i <= W; i++) begin
         lo   = (i > K) ? i - K : 0;
         len  = i - lo;
         mask = (32'd1 << len) - 1;
         sx   = (32'(x) >> lo) & mask;
         sy   = (32'(y) >> lo) & mask;
         c    = ((sx + sy) >> len) & 1;
         if (i == W) r[W] = c[0];
         else        r[i] = x[i] ^ y[i] ^ c[0];
      end
      return r;
   endfunction

   // True when some generated carry passes through K or more propagate bits.
   function automatic bit has_long_run(input logic [W-1:0] x, input logic [W-1:0] y);
      int run;
      for (int j = 0; j < W; j++) begin
         if (x[j] & y[j]) begin
            run = 0;
            for (int m = j + 1; m < W && (x[m] ^ y[m]); m++) run++;
            if (run >= K) return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   task automatic apply(input logic [W-1:0] x, input logic [W-1:0] y);
      a = x;
      b = y;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [W:0]   exp;
      string        tag;
   } vec_t;

   vec_t dir[8];
   logic [W-1:0] rx, ry;
   logic [W:0]   exact;

   initial begin
      dir[0] = '{16'h0000, 16'h0000, 17'h00000, "zero"};
      dir[1] = '{16'h0000, 16'h0001, 17'h00001, "unit"};
      dir[2] = '{16'hABCD, 16'h0000, 17'h0ABCD, "abcd_plus_0"};
      dir[3] = '{16'h5555, 16'hAAAA, 17'h0FFFF, "long_prop"};
      dir[4] = '{16'h00FF, 16'h0001, 17'h000E0, "drop_00ff"};
      dir[5] = '{16'h8943, 16'hFFFF, 17'h18902, "drop_8943"};
      dir[6] = '{16'h29AF, 16'h7A1B, 17'h0A3CA, "b2b_0"};
      dir[7] = '{16'h1100, 16'h1111, 17'h02211, "b2b_1"};

      rst = 1'b1;
      a   = 16'hFFFF;
      b   = 16'hFFFF;
      @(posedge clk);
      #1;
      check("reset_wins", res, 17'h00000);
      rst = 1'b0;
      apply(16'hFFFF, 16'hFFFF);
      check("after_reset", res, 17'h1FFFE);

      // Directed vectors on consecutive cycles; last three form the
      // back-to-back stream.
      for (int i = 0; i < 8; i++) begin
         apply(dir[i].x, dir[i].y);
         check(dir[i].tag, res, dir[i].exp);
         check({dir[i].tag, "_model"}, res, ref_aca(dir[i].x, dir[i].y));
      end
      apply(16'h4096, 16'h2048);
      check("b2b_2", res, 17'h060DE);

      // Output holds its value only for one cycle of latency: check before
      // the next edge that it still reflects the previous operands.
      a = 16'h0001;
      b = 16'h0001;
      #2;
      check("latency_hold", res, 17'h060DE);
      @(posedge clk);
      #1;
      check("latency_update", res, 17'h00002);

      for (int n = 0; n < 10000; n++) begin
         rx = 16'($urandom);
         ry = 16'($urandom);
         apply(rx, ry);
         check("rand_model", res, ref_aca(rx, ry));
         if (!has_long_run(rx, ry)) begin
            exact = {1'b0, rx} + {1'b0, ry};
            check("rand_exact", res, exact);
         end
      end

      rst = 1'b1;
      apply(16'h1234, 16'h4321);
      check("mid_reset", res, 17'h00000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
